add_pipe_32bit: RTL and testbench

ADD_PIPE_32BIT -- requirements
Module: add_pipe_32bit

---
 rtl/add_pipe_32bit.sv | 211 +++++++++++++++++++++
 tb/tb_add_pipe_32bit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipe_32bit.sv
// -----------------------------------------------------------------------------
// add_pipe_32bit
//
// Two-stage pipelined N-bit adder with valid/ready handshakes on both sides.
//
//   Stage 1 adds the low halves of the operands plus carry-in. It registers
//   the low-half sum, the low-half carry and the untouched high halves. The
//   top bits of the high halves are a[N-1] and b[N-1].
//   Stage 2 is the output register. It adds the registered high halves with
//   the stage-1 carry and latches sum, cout and ovf.
//
// An operand set accepted on edge k is captured by stage 1 on that edge.
// It reaches the output register on edge k+1, so out_valid is high for the
// cycle leading up to edge k+2, where it can transfer out. Each stage holds
// one set, so at most two sets are in flight. With out_ready held high the
// pipeline accepts one set per cycle and inserts no bubbles.
//
// Parameters
//   N           operand width; must be even and at least 4 (default 32)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset; clears both valid bits and
//               all data registers
//   in_valid    operand set present on a, b, cin
//   in_ready    combinational: stage 1 empty or advancing this cycle; it
//               does not depend on in_valid
//   a, b        N-bit operands (unsigned or two's complement)
//   cin         carry-in
//   out_valid   result present on sum, cout, ovf
//   out_ready   downstream accepts the result this cycle
//   sum         registered (a + b + cin) mod 2^N
//   cout        carry out of bit N-1
//   ovf         signed overflow: operand signs equal and sum sign differs
//
// Optional feature (macro ADD_PIPE_STATS_EN)
//   txn_count   16-bit count of output transfers, wraps FFFF -> 0000
//   ovf_count   16-bit count of output transfers with ovf=1, saturates at FFFF
// When the macro is undefined, these ports and counters do not exist.
// -----------------------------------------------------------------------------
module add_pipe_32bit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
`ifdef ADD_PIPE_STATS_EN
    ,
    output logic [15:0]  txn_count,
    output logic [15:0]  ovf_count
`endif
);

    localparam int H = N / 2;

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic         s1_valid_reg;
    logic [H-1:0] s1_lo_sum_reg;
    logic         s1_lo_carry_reg;
    logic [H-1:0] s1_a_hi_reg;      // MSB is a[N-1]
    logic [H-1:0] s1_b_hi_reg;      // MSB is b[N-1]

    logic         out_valid_reg;
    logic [N-1:0] sum_reg;
    logic         cout_reg;
    logic         ovf_reg;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic out_advance;   // output register can take a new value this cycle
    logic s1_advance;    // stage 1 moves its set into the output register
    logic in_xfer;
    logic out_xfer;

    // The output register is free if it is empty or is being drained on
    // this edge. Stage 1 can then hand over its set. If stage 1 is empty,
    // it can always take a new set. Only registered state and out_ready
    // feed in_ready.
    assign out_advance = !out_valid_reg || out_ready;
    assign s1_advance  = s1_valid_reg && out_advance;
    assign in_ready    = !s1_valid_reg || out_advance;
    assign in_xfer     = in_valid && in_ready;
    assign out_xfer    = out_valid_reg && out_ready;

    // ------------------------------------------------------------------
    // Stage 1 arithmetic: low half plus carry-in
    // ------------------------------------------------------------------
    logic [H:0] lo_add;
    assign lo_add = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};

    // ------------------------------------------------------------------
    // Stage 2 arithmetic: high half plus the carry out of stage 1
    // ------------------------------------------------------------------
    logic [H:0]   hi_add;
    logic [N-1:0] sum_next;
    logic         cout_next;
    logic         ovf_next;

    assign hi_add    = {1'b0, s1_a_hi_reg} + {1'b0, s1_b_hi_reg}
                     + {{H{1'b0}}, s1_lo_carry_reg};
    assign sum_next  = {hi_add[H-1:0], s1_lo_sum_reg};
    assign cout_next = hi_add[H];
    // Signed overflow: both operands have the same sign and the result sign
    // differs from it.
    assign ovf_next  = (s1_a_hi_reg[H-1] == s1_b_hi_reg[H-1])
                    && (hi_add[H-1] != s1_a_hi_reg[H-1]);

    // ------------------------------------------------------------------
    // Valid-bit next-state
    // ------------------------------------------------------------------
    logic s1_valid_next;
    logic out_valid_next;

    // Stage 1 reloads its valid bit whenever it is allowed to accept, and
    // otherwise holds. The output register follows stage 1 whenever it is
    // free, and otherwise holds its current result.
    assign s1_valid_next  = in_ready    ? in_valid     : s1_valid_reg;
    assign out_valid_next = out_advance ? s1_valid_reg : out_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg    <= 1'b0;
            s1_lo_sum_reg   <= '0;
            s1_lo_carry_reg <= 1'b0;
            s1_a_hi_reg     <= '0;
            s1_b_hi_reg     <= '0;
        end else begin
            s1_valid_reg <= s1_valid_next;
            // Data loads only on a real transfer. Operands seen while
            // in_valid=0 never reach the pipeline.
            if (in_xfer) begin
                s1_lo_sum_reg   <= lo_add[H-1:0];
                s1_lo_carry_reg <= lo_add[H];
                s1_a_hi_reg     <= a[N-1:H];
                s1_b_hi_reg     <= b[N-1:H];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 / output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            out_valid_reg <= out_valid_next;
            // Result fields change only when a new set moves in. Under
            // backpressure they stay frozen.
            if (s1_advance) begin
                sum_reg  <= sum_next;
                cout_reg <= cout_next;
                ovf_reg  <= ovf_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

`ifdef ADD_PIPE_STATS_EN
    // ------------------------------------------------------------------
    // Transfer statistics
    // ------------------------------------------------------------------
    logic [15:0] txn_count_reg;
    logic [15:0] ovf_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count_reg <= '0;
            ovf_count_reg <= '0;
        end else if (out_xfer) begin
            // The transfer count wraps on purpose. The overflow count
            // saturates, so a large value never rolls back to a small one.
            txn_count_reg <= txn_count_reg + 16'd1;
            if (ovf_reg && (ovf_count_reg != 16'hFFFF)) begin
                ovf_count_reg <= ovf_count_reg + 16'd1;
            end
        end
    end

    assign txn_count = txn_count_reg;
    assign ovf_count = ovf_count_reg;
`else
    // Without statistics, the output handshake is consumed only by the
    // downstream logic.
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_add_pipe_32bit.sv
// -----------------------------------------------------------------------------
// tb_add_pipe_32bit
//
// Testbench for add_pipe_32bit with N=32.
//
// A reference model computes each expected result with wide integer
// arithmetic. Results are queued in acceptance order. A compare process
// runs on every falling clock edge and checks:
//   - each output transfer against the queue,
//   - that held outputs stay stable under backpressure,
//   - that in_ready matches the current occupancy.
// Directed sequences add literal checks for latency, boundary values,
// backpressure, reset, and (with ADD_PIPE_STATS_EN) the statistics counters.
// -----------------------------------------------------------------------------
module tb_add_pipe_32bit;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef ADD_PIPE_STATS_EN
    logic [15:0]  txn_count;
    logic [15:0]  ovf_count;
`endif

    int checks   = 0;
    int failures = 0;

    add_pipe_32bit #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
`ifdef ADD_PIPE_STATS_EN
        ,
        .txn_count (txn_count),
        .ovf_count (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // Returns {ovf, cout, sum}, computed from integer arithmetic.
    // ------------------------------------------------------------------
    function automatic logic [N+1:0] model(input logic [N-1:0] x,
                                           input logic [N-1:0] y,
                                           input logic c);
        longint unsigned u;
        longint          s;
        logic            v;
        u = {32'd0, x} + {32'd0, y} + {63'd0, c};
        s = longint'($signed(x)) + longint'($signed(y)) + longint'({63'd0, c});
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {v, u[N], u[N-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process (falling edge, when all signals are stable)
    // ------------------------------------------------------------------
    logic [N+1:0] exp_q[$];
    logic         hold_valid = 1'b0;
    logic [N+1:0] hold_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_valid = 1'b0;
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_in_ready",  {63'd0, in_ready},  64'd1);
        end else begin
            // Both stages are full only when two sets are in flight.
            check("in_ready_rule", {63'd0, in_ready},
                  {63'd0, (exp_q.size() < 2) || out_ready});
            if (hold_valid) begin
                check("hold_valid",  {63'd0, out_valid}, 64'd1);
                check("hold_result", {30'd0, ovf, cout, sum}, {30'd0, hold_val});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stale_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    check("stream_result", {30'd0, ovf, cout, sum},
                          {30'd0, exp_q.pop_front()});
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_val   = {ovf, cout, sum};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] x,
                         input logic [N-1:0] y, input logic c);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    // Send one set into an empty pipeline with out_ready=1 and check
    // exact latency plus literal result values.
    task automatic send_latency(input string name, input logic [N-1:0] x,
                                input logic [N-1:0] y, input logic c,
                                input logic [N-1:0] es, input logic ec,
                                input logic eo);
        out_ready = 1'b1;
        drive(1'b1, x, y, c);
        check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
        step();                                  // accepted on edge k
        drive(1'b0, 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
        check({name, "_not_early"}, {63'd0, out_valid}, 64'd0);
        step();                                  // in output register after k+1
        check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({name, "_sum"},   {32'd0, sum},       {32'd0, es});
        check({name, "_cout"},  {63'd0, cout},      {63'd0, ec});
        check({name, "_ovf"},   {63'd0, ovf},       {63'd0, eo});
        step();                                  // left on edge k+2
        check({name, "_drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    logic [N-1:0] bb_a [3];
    logic [N-1:0] bb_b [3];
    logic         bb_c [3];
    logic [N-1:0] bb_s [3];
    logic         bb_co[3];
    logic         bb_ov[3];

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_in_ready",  {63'd0, in_ready},  64'd1);
        check("reset_sum",       {32'd0, sum},       64'd0);
        check("reset_cout_ovf",  {62'd0, cout, ovf}, 64'd0);
        rst_n = 1'b1;

        // The first edge after release accepts the first set.
        send_latency("max_pos_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0,
                     32'h80000000, 1'b0, 1'b1);
        send_latency("all_ones_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0,
                     32'h00000000, 1'b1, 1'b0);
        send_latency("half_carry",   32'h0000FFFF, 32'h00000000, 1'b1,
                     32'h00010000, 1'b0, 1'b0);

        // Back-to-back sets with out_ready=1: results on three consecutive
        // cycles, in order.
        bb_a[0] = 32'h00000001; bb_b[0] = 32'h00000002; bb_c[0] = 1'b0;
        bb_s[0] = 32'h00000003; bb_co[0] = 1'b0; bb_ov[0] = 1'b0;
        bb_a[1] = 32'hFFFFFFFF; bb_b[1] = 32'hFFFFFFFF; bb_c[1] = 1'b1;
        bb_s[1] = 32'hFFFFFFFF; bb_co[1] = 1'b1; bb_ov[1] = 1'b0;
        bb_a[2] = 32'h80000000; bb_b[2] = 32'h80000000; bb_c[2] = 1'b0;
        bb_s[2] = 32'h00000000; bb_co[2] = 1'b1; bb_ov[2] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(1'b1, bb_a[c], bb_b[c], bb_c[c]);
            else       drive(1'b0, '0, '0, 1'b0);
            step();
            check("b2b_valid", {63'd0, out_valid}, {63'd0, (c >= 1) && (c <= 3)});
            if (c >= 1 && c <= 3) begin
                check("b2b_result", {30'd0, ovf, cout, sum},
                      {30'd0, bb_ov[c-1], bb_co[c-1], bb_s[c-1]});
            end
        end

        // Backpressure: two sets accepted, the third stalls, the output
        // holds, and the third is accepted as the first leaves.
        out_ready = 1'b0;
        drive(1'b1, 32'd10, 32'd20, 1'b0);                 // A -> 30
        step();
        drive(1'b1, 32'h12345678, 32'h11111111, 1'b0);     // B -> 23456789
        step();
        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 1'b1);     // C -> 0, cout
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_stall_ready", {63'd0, in_ready}, 64'd0);
            check("bp_stall_valid", {63'd0, out_valid}, 64'd1);
            check("bp_stall_sum",   {32'd0, sum}, 64'h1E);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("bp_second", {31'd0, cout, sum}, {31'd0, 1'b0, 32'h23456789});
        step();
        check("bp_third", {30'd0, ovf, cout, sum}, {30'd0, 2'b01, 32'h00000000});
        step();
        check("bp_empty", {63'd0, out_valid}, 64'd0);

        // Reset with two sets in flight.
        out_ready = 1'b0;
        drive(1'b1, 32'h00000005, 32'h00000006, 1'b0);
        step();
        drive(1'b1, 32'h00000007, 32'h00000008, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b0);
        check("mid_full", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready},  64'd1);
        check("mid_rst_sum",   {32'd0, sum},       64'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_stale", {63'd0, out_valid}, 64'd0);
        end

        // Mixed traffic with random stalls. The compare process checks it.
        for (int i = 0; i < 80; i++) begin
            logic [N-1:0] x;
            logic [N-1:0] y;
            case (i % 5)
                0:       begin x = 32'h7FFFFFFF; y = 32'($urandom_range(0, 3)); end
                1:       begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2:       begin x = 32'h0000FFFF; y = 32'h00000000; end
                default: begin x = $urandom; y = $urandom; end
            endcase
            drive(1'($urandom_range(0, 1)), x, y, 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", {63'd0, out_valid}, 64'd0);

`ifdef ADD_PIPE_STATS_EN
        // 70000 transfers including 5 overflows.
        rst_n = 1'b0;
        step();
        check("stats_reset", {32'd0, txn_count, ovf_count}, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (i == 100 || i == 2000 || i == 30000 || i == 50000 || i == 69000)
                drive(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b0);
            else
                drive(1'b1, 32'(i), 32'(i), 1'b0);
            step();
        end
        drive(1'b0, '0, '0, 1'b0);
        repeat (4) step();
        check("stats_txn", {48'd0, txn_count}, 64'd4464);
        check("stats_ovf", {48'd0, ovf_count}, 64'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
